// File: rtl/serv_uart_rx_pkg.sv
// serv_uart_rx shared types and constants.
// Optional parity build: define SERV_UART_RX_PARITY_EN.
package serv_uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam int DATA_BITS = 8;

  // Line idles high, so the synchroniser starts there.
  localparam logic SYNC_RST_VAL = 1'b1;

endpackage

// File: rtl/serv_uart_rx_fifo.sv
// serv_uart_rx byte buffer.
// First-word-fall-through FIFO; head holds last value when empty.
module serv_uart_rx_fifo
  import serv_uart_rx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] last_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign data    = empty ? last_q : mem[rd_ptr];

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and the held head value.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
      if (!empty) last_q <= mem[rd_ptr];
    end
  end

endmodule

// File: rtl/serv_uart_rx.sv
// serv_uart_rx: 8N1 UART receiver with FWFT byte FIFO.
// Define SERV_UART_RX_PARITY_EN for an even-parity bit.
module serv_uart_rx
  import serv_uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 139,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       wb_clk,
  input  logic       wb_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overflow,
  output logic       o_busy
`ifdef SERV_UART_RX_PARITY_EN
  ,
  output logic       o_parity_err
`endif
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL =
    CW'(CLKS_PER_BIT - 1);

  rx_state_t            state, state_n;
  logic [1:0]           sync;
  logic                 rx_s;
  logic [CW-1:0]        cnt, cnt_n;
  logic [2:0]           idx, idx_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic                 tick;
  logic                 push;
  logic                 ferr_n;
  logic                 drop;
  logic                 full;
  logic                 empty;
  logic [FW:0]          count;
`ifdef SERV_UART_RX_PARITY_EN
  logic                 pbad, pbad_n;
  logic                 perr_n;
`endif

  assign rx_s    = sync[1];
  assign tick    = (cnt == '0);
  assign o_busy  = (state != IDLE);
  assign o_valid = ~empty;
  assign drop    = push & full & ~(i_ready & ~empty);

  // Two-flop synchroniser for the asynchronous line.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) sync <= {2{SYNC_RST_VAL}};
    else        sync <= {sync[0], i_rx};
  end

  // Deframer state and datapath registers.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      sh          <= '0;
      o_frame_err <= 1'b0;
      o_overflow  <= 1'b0;
`ifdef SERV_UART_RX_PARITY_EN
      pbad         <= 1'b0;
      o_parity_err <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      sh          <= sh_n;
      o_frame_err <= ferr_n;
      if (drop) o_overflow <= 1'b1;
`ifdef SERV_UART_RX_PARITY_EN
      pbad         <= pbad_n;
      o_parity_err <= perr_n;
`endif
    end
  end

  // Next-state: sample at counter zero, reload on each bit.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    push    = 1'b0;
    ferr_n  = 1'b0;
`ifdef SERV_UART_RX_PARITY_EN
    pbad_n  = pbad;
    perr_n  = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = HALF;
        end
      end
      START: begin
        if (!tick) begin
          cnt_n = cnt - 1'b1;
        end else if (rx_s) begin
          state_n = IDLE;
        end else begin
          state_n = DATA;
          idx_n   = '0;
          cnt_n   = FULL;
`ifdef SERV_UART_RX_PARITY_EN
          pbad_n  = 1'b0;
`endif
        end
      end
      DATA: begin
        if (!tick) begin
          cnt_n = cnt - 1'b1;
        end else begin
          sh_n[idx] = rx_s;
          idx_n     = idx + 1'b1;
          cnt_n     = FULL;
          if (idx == 3'(DATA_BITS - 1)) begin
`ifdef SERV_UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
      PARITY: begin
        if (!tick) begin
          cnt_n = cnt - 1'b1;
        end else begin
          state_n = STOP;
          cnt_n   = FULL;
`ifdef SERV_UART_RX_PARITY_EN
          if (rx_s != ^sh) begin
            pbad_n = 1'b1;
            perr_n = 1'b1;
          end
`endif
        end
      end
      STOP: begin
        if (!tick) begin
          cnt_n = cnt - 1'b1;
        end else begin
          cnt_n = FULL;
          if (rx_s) begin
            state_n = IDLE;
`ifdef SERV_UART_RX_PARITY_EN
            push    = ~pbad;
`else
            push    = 1'b1;
`endif
          end else begin
            state_n = BREAK;
            ferr_n  = 1'b1;
          end
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_n = IDLE;
          cnt_n   = FULL;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  serv_uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (wb_clk),
    .rst       (wb_rst),
    .push      (push),
    .push_data (sh),
    .pop       (i_ready),
    .data      (o_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  logic unused_ok;
  assign unused_ok = ^count;

endmodule

// File: tb/tb_serv_uart_rx.sv
// serv_uart_rx directed bench.
// Parity cases run when SERV_UART_RX_PARITY_EN is defined.
module tb_serv_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       wb_rst;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_frame_err;
  logic       o_overflow;
  logic       o_busy;
`ifdef SERV_UART_RX_PARITY_EN
  logic       o_parity_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  logic [7:0] rxq [$];

  serv_uart_rx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .wb_clk       (clk),
    .wb_rst       (wb_rst),
    .i_rx         (i_rx),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_frame_err  (o_frame_err),
    .o_overflow   (o_overflow),
    .o_busy       (o_busy)
`ifdef SERV_UART_RX_PARITY_EN
    ,
    .o_parity_err (o_parity_err)
`endif
  );

  always #5 clk = ~clk;

  // Consumer model: record every accepted byte and error pulse.
  always @(negedge clk) begin
    if (o_valid && i_ready) rxq.push_back(o_data);
    if (o_frame_err) ferr_cnt++;
`ifdef SERV_UART_RX_PARITY_EN
    if (o_parity_err) perr_cnt++;
`endif
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input int act,
                     input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input logic stop,
                            input logic par);
    i_rx = 1'b0;
    wait_cyc(CPB);
    for (int b = 0; b < 8; b++) begin
      i_rx = d[b];
      wait_cyc(CPB);
    end
`ifdef SERV_UART_RX_PARITY_EN
    i_rx = par;
    wait_cyc(CPB);
`else
    if (par === 1'bx) i_rx = 1'b1;
`endif
    i_rx = stop;
    wait_cyc(CPB);
    i_rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         hold;
    int         exp_n;
    int         exp_ferr;
  } vec_t;

  vec_t tv [4];

  initial begin
    tv[0] = '{8'h55, 1'b1, 0, 1, 0};
    tv[1] = '{8'hA3, 1'b1, 0, 1, 0};
    tv[2] = '{8'h3C, 1'b0, 40, 0, 1};
    tv[3] = '{8'h7E, 1'b1, 0, 1, 0};

    wb_rst  = 1'b1;
    i_rx    = 1'b1;
    i_ready = 1'b1;
    wait_cyc(3);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_data", int'(o_data), 8'h00);
    chk("rst_ferr", int'(o_frame_err), 0);
    chk("rst_ovf", int'(o_overflow), 0);
    chk("rst_busy", int'(o_busy), 0);
    wb_rst = 1'b0;
    wait_cyc(4);

    // Table: normal frames, bad stop with held-low line.
    for (int i = 0; i < 4; i++) begin
      rxq.delete();
      ferr_cnt = 0;
      send_frame(tv[i].d, tv[i].stop, ^tv[i].d);
      if (tv[i].hold > 0) begin
        i_rx = 1'b0;
        wait_cyc(tv[i].hold);
        i_rx = 1'b1;
      end
      wait_cyc(24);
      chk($sformatf("tv%0d_n", i), rxq.size(),
          tv[i].exp_n);
      if (tv[i].exp_n > 0 && rxq.size() > 0)
        chk($sformatf("tv%0d_byte", i),
            int'(rxq[0]), int'(tv[i].d));
      chk($sformatf("tv%0d_ferr", i), ferr_cnt,
          tv[i].exp_ferr);
      chk($sformatf("tv%0d_ovf", i),
          int'(o_overflow), 0);
      chk($sformatf("tv%0d_valid", i),
          int'(o_valid), 0);
    end

    // Short low glitch must not start a frame.
    rxq.delete();
    ferr_cnt = 0;
    i_rx = 1'b0;
    wait_cyc(5);
    i_rx = 1'b1;
    chk("glitch_busy_on", int'(o_busy), 1);
    wait_cyc(8);
    chk("glitch_busy_off", int'(o_busy), 0);
    wait_cyc(20);
    chk("glitch_n", rxq.size(), 0);
    chk("glitch_ferr", ferr_cnt, 0);

    // Overflow: five bytes into a four-deep FIFO.
    rxq.delete();
    i_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      logic [7:0] kb;
      kb = 8'(k);
      send_frame(kb, 1'b1, ^kb);
      wait_cyc(4);
      if (k == 4) begin
        chk("ovf_before", int'(o_overflow), 0);
        chk("ovf_valid", int'(o_valid), 1);
        chk("ovf_head", int'(o_data), 1);
      end
    end
    chk("ovf_after", int'(o_overflow), 1);
    i_ready = 1'b1;
    wait_cyc(10);
    chk("ovf_n", rxq.size(), 4);
    for (int k = 0; k < 4 && k < rxq.size(); k++)
      chk($sformatf("ovf_b%0d", k),
          int'(rxq[k]), k + 1);
    chk("ovf_empty", int'(o_valid), 0);
    chk("ovf_hold", int'(o_data), 4);

    // Reset pulse during bit 3 of 0xFF.
    rxq.delete();
    i_rx = 1'b0;
    wait_cyc(CPB);
    i_rx = 1'b1;
    wait_cyc(3 * CPB + 8);
    chk("mid_busy", int'(o_busy), 1);
    wb_rst = 1'b1;
    wait_cyc(1);
    wb_rst = 1'b0;
    chk("mr_busy", int'(o_busy), 0);
    chk("mr_valid", int'(o_valid), 0);
    chk("mr_data", int'(o_data), 0);
    chk("mr_ferr", int'(o_frame_err), 0);
    chk("mr_ovf", int'(o_overflow), 0);
    wait_cyc(6 * CPB);
    send_frame(8'h42, 1'b1, ^8'h42);
    wait_cyc(24);
    chk("mr_n", rxq.size(), 1);
    if (rxq.size() > 0)
      chk("mr_byte", int'(rxq[0]), 8'h42);

`ifdef SERV_UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, parity bit must be 1.
    rxq.delete();
    perr_cnt = 0;
    send_frame(8'h07, 1'b1, 1'b0);
    wait_cyc(24);
    chk("par_bad_err", perr_cnt, 1);
    chk("par_bad_n", rxq.size(), 0);
    rxq.delete();
    perr_cnt = 0;
    send_frame(8'h07, 1'b1, 1'b1);
    wait_cyc(24);
    chk("par_ok_err", perr_cnt, 0);
    chk("par_ok_n", rxq.size(), 1);
    if (rxq.size() > 0)
      chk("par_ok_byte", int'(rxq[0]), 8'h07);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serv_uart_rx.md
Name: serv_uart_rx

Overview:
- Serial receive stage directly downstream of the SoC's bit-banged serial output (`q`/`o_data` line) in simulation and FPGA builds.
- Synchronises and oversamples the line, deframes 8N1 UART characters LSB-first, and buffers bytes in a small FIFO.
- The FIFO is presented with a valid/ready handshake to a console or checker, replacing ad-hoc testbench bit decoding.

Parameters:
- CLKS_PER_BIT, 139, wb_clk cycles per bit (16 MHz / 115200); legal range 4..65535.
- FIFO_DEPTH, 8, byte entries; power of two, at least 2.

Ports:
- `wb_clk` in 1: system clock.
- `wb_rst` in 1: synchronous, active-high reset.
- `i_rx` in 1: asynchronous serial line; idles high.
- `o_data` out 8: FIFO head byte (first-word-fall-through).
- `o_valid` out 1: FIFO non-empty.
- `i_ready` in 1: consumer accepts the head byte when `o_valid` and `i_ready` are both high.
- `o_frame_err` out 1: one-cycle pulse when a stop bit is sampled low.
- `o_overflow` out 1: sticky; a byte was dropped because the FIFO was full.
- `o_busy` out 1: deframer is not in IDLE.

Behaviour:
- Reset values: `o_valid`=0, `o_data`=0, `o_frame_err`=0, `o_overflow`=0, `o_busy`=0, FIFO empty, state IDLE, synchroniser flops=1.
- `i_rx` passes through a 2-flop synchroniser; all logic uses the synchronised value `rx_s`.
- Bit counter width is `$clog2(CLKS_PER_BIT)`. The sample counter reloads on every state transition.
- IDLE: on `rx_s`==0, go to START and load the counter with CLKS_PER_BIT/2 - 1.
- START: at counter 0, sample `rx_s`.
  - If it is 1, treat it as a glitch and return to IDLE; no error is flagged.
  - If it is 0, go to DATA with bit index 0 and reload CLKS_PER_BIT-1.
- DATA: at each counter 0, shift `rx_s` into bit[index]. After index 7, go to STOP, or to PARITY when the option is enabled.
- STOP: at counter 0, sample `rx_s`.
  - If 1: push the byte, return to IDLE.
  - If 0: pulse `o_frame_err`, discard the byte, go to BREAK.
- BREAK: wait for `rx_s`==1, then go to IDLE. This prevents a held-low line from re-triggering.
- Latency: the pushed byte appears on `o_data` with `o_valid`=1 on the cycle after the stop-bit sample.
- FIFO:
  - Pop when `o_valid` and `i_ready` are both high.
  - Push while full with no simultaneous pop: drop the byte and set `o_overflow` (cleared only by reset).
  - Push and pop in the same cycle, including when full: both take effect and occupancy is unchanged.
  - Pop while empty: ignored.
  - Pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. The count register is one bit wider.
- Reset mid-frame: on the next edge the FSM returns to IDLE and the FIFO empties. A partial frame is lost.
- `o_data` holds its last value while the FIFO is empty. Checkers must qualify it with `o_valid`.

Optional Feature:
- Macro: `SERV_UART_RX_PARITY_EN`.
- Defined:
  - A PARITY state sits between DATA and STOP and samples an even-parity bit.
  - On mismatch the byte is discarded and `o_parity_err` (an extra 1-bit output) pulses for one cycle at the parity sample.
  - The FSM still proceeds to STOP.
- Undefined: 8N1 only; no PARITY state and no `o_parity_err` port.

Decomposition:
- Package `serv_uart_rx_pkg`:
  - State enum: IDLE, START, DATA, PARITY, STOP, BREAK.
  - `DATA_BITS`=8.
  - Synchroniser reset value constant.
- Sub-module `serv_uart_rx_fifo`: parameterised FWFT FIFO (width, depth) with push/pop/full/empty/count. It is instantiated once.

Test Plan (bench uses CLKS_PER_BIT=16, FIFO_DEPTH=4):
- Send 0x55 then 0xA3 with `i_ready`=1 → `o_valid` pulses twice with `o_data`=0x55 then 0xA3; `o_frame_err` and `o_overflow` remain 0.
- Drive a 5-cycle low glitch on an idle line → no byte, `o_frame_err`=0; `o_busy` returns to 0 within 8 cycles of the glitch end.
- Send 0x3C with the stop bit forced low, hold low 40 cycles, then send 0x7E → one `o_frame_err` pulse, only 0x7E is delivered.
- With `i_ready`=0, send 0x01..0x05 → first four bytes are held; `o_overflow`=1 after the fifth stop bit. Raising `i_ready` yields 0x01..0x04, then `o_valid`=0.
- Assert `wb_rst` for 1 cycle during bit 3 of 0xFF → outputs return to reset values; the next clean frame 0x42 is received correctly.
- With the parity option enabled, send 0x07 with parity=0 → `o_parity_err` pulses and no byte is delivered. Send 0x07 with parity=1 → 0x07 is delivered.
